// File: rtl/alu_pkg.sv
// Shared opcode/funct constants, decoded-op and multiplier-state enums, and the decode function.
// Pure declarations; no latency or flow control lives here.
package alu_pkg;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_SRLV  = 6'b000110;
    localparam logic [5:0] FN_SRAV  = 6'b000111;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_FIX
    } mul_state_e;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_SLT, OP_SLTU,
        OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV,
        OP_MFHI, OP_MFLO, OP_MULT, OP_MULTU,
        OP_ILL
    } alu_op_e;

    function automatic alu_op_e alu_decode(input logic [1:0] alu_op, input logic [5:0] fn);
        alu_op_e op;
        op = OP_ILL;
        if (alu_op == ALUOP_ADD) begin
            op = OP_ADD;
        end else if (alu_op == ALUOP_SUB) begin
            op = OP_SUB;
        end else begin
            case (fn)
                FN_ADD, FN_ADDU: op = OP_ADD;
                FN_SUB, FN_SUBU: op = OP_SUB;
                FN_AND:          op = OP_AND;
                FN_OR:           op = OP_OR;
                FN_XOR:          op = OP_XOR;
                FN_NOR:          op = OP_NOR;
                FN_SLT:          op = OP_SLT;
                FN_SLTU:         op = OP_SLTU;
                FN_SLL:          op = OP_SLL;
                FN_SRL:          op = OP_SRL;
                FN_SRA:          op = OP_SRA;
                FN_SLLV:         op = OP_SLLV;
                FN_SRLV:         op = OP_SRLV;
                FN_SRAV:         op = OP_SRAV;
                FN_MFHI:         op = OP_MFHI;
                FN_MFLO:         op = OP_MFLO;
                FN_MULT:         op = OP_MULT;
                FN_MULTU:        op = OP_MULTU;
                default:         op = OP_ILL;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operation request and registered-response bundle between the datapath control and the ALU.
// master drives the request fields; slave (the ALU) drives the results and status pulses.
interface alu_exec_unit_if #(parameter int WIDTH = 32);
    localparam int SH_W = $clog2(WIDTH);

    logic [1:0]       alu_op;
    logic [5:0]       fn_field;
    logic [SH_W-1:0]  shamt;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;
    logic             done;
    logic             illegal;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output alu_op, fn_field, shamt, start, a, b,
        input  result, zero, busy, done, illegal, hi, lo
    );

    modport slave (
        input  alu_op, fn_field, shamt, start, a, b,
        output result, zero, busy, done, illegal, hi, lo
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier on magnitudes with sign fix-up; WIDTH iterations then one FIX cycle (done_o).
// start_i is honoured in IDLE and FIX only; busy_o covers the iteration cycles.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);
    localparam int CNT_W = $clog2(WIDTH);

    mul_state_e           state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [WIDTH-1:0]     a_mag, b_mag;

    assign a_mag = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_mag = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        case (state_q)
            ST_IDLE, ST_FIX: begin
                if (state_q == ST_FIX) begin
                    state_d = ST_IDLE;
                end
                if (start_i) begin
                    state_d  = ST_MUL;
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    acc_d    = '0;
                    neg_d    = signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    cnt_d    = CNT_W'(WIDTH - 1);
                end
            end
            ST_MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
        end
    end

    // acc_q is only reloaded at the end of FIX, so the fixed-up product stays valid all through FIX.
    assign busy_o    = (state_q == ST_MUL);
    assign done_o    = (state_q == ST_FIX);
    assign product_o = neg_q ? -acc_q : acc_q;

endmodule

// File: rtl/alu_exec_unit.sv
// Decode + execute with registered result/zero and HI/LO; single-cycle ops respond one edge after start.
// Multiplies respond WIDTH+1 cycles after start; start is dropped while busy, no queueing.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    alu_exec_unit_if.slave   io
);
    localparam int SH_W = $clog2(WIDTH);

    alu_op_e            op;
    logic               accept, mul_start, mul_signed, mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0]   prod_hi, prod_lo;
    logic [SH_W-1:0]    var_sh;
    logic [WIDTH-1:0]   alu_res;

    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               done_q, done_d;
    logic               ill_q, ill_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    assign op         = alu_decode(io.alu_op, io.fn_field);
    assign accept     = io.start && !mul_busy;
    assign mul_start  = accept && ((op == OP_MULT) || (op == OP_MULTU));
    assign mul_signed = (op == OP_MULT);
    assign var_sh     = io.a[SH_W-1:0];
    assign prod_hi    = mul_prod[2*WIDTH-1:WIDTH];
    assign prod_lo    = mul_prod[WIDTH-1:0];

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk_i     (clk),
        .rst_i     (reset),
        .start_i   (mul_start),
        .signed_i  (mul_signed),
        .a_i       (io.a),
        .b_i       (io.b),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:   alu_res = io.a + io.b;
            OP_SUB:   alu_res = io.a - io.b;
            OP_AND:   alu_res = io.a & io.b;
            OP_OR:    alu_res = io.a | io.b;
            OP_XOR:   alu_res = io.a ^ io.b;
            OP_NOR:   alu_res = ~(io.a | io.b);
            OP_SLT:   alu_res = WIDTH'($signed(io.a) < $signed(io.b));
            OP_SLTU:  alu_res = WIDTH'(io.a < io.b);
            OP_SLL:   alu_res = io.b << io.shamt;
            OP_SRL:   alu_res = io.b >> io.shamt;
            OP_SRA:   alu_res = $signed(io.b) >>> io.shamt;
            OP_SLLV:  alu_res = io.b << var_sh;
            OP_SRLV:  alu_res = io.b >> var_sh;
            OP_SRAV:  alu_res = $signed(io.b) >>> var_sh;
            OP_MFHI:  alu_res = hi_q;
            OP_MFLO:  alu_res = lo_q;
            default:  alu_res = '0;
        endcase
    end

    // HI/LO commit at the end of the FIX cycle, so an mfhi/mflo accepted in that cycle still sees the old pair.
    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        ill_d    = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (mul_done) begin
            hi_d     = prod_hi;
            lo_d     = prod_lo;
            result_d = prod_lo;
            zero_d   = (prod_lo == '0);
        end
        if (accept && !mul_start) begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            done_d   = 1'b1;
            ill_d    = (op == OP_ILL);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
            ill_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
            ill_q    <= ill_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // During FIX the visible outputs already carry the product; the registers catch up on the next edge.
    assign io.result  = mul_done ? prod_lo : result_q;
    assign io.zero    = mul_done ? (prod_lo == '0) : zero_q;
    assign io.hi      = mul_done ? prod_hi : hi_q;
    assign io.lo      = mul_done ? prod_lo : lo_q;
    assign io.done    = done_q | mul_done;
    assign io.illegal = ill_q;
    assign io.busy    = mul_busy;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboarded random + directed bench for alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic        ill;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    exp_t        sb[$];
    logic [31:0] m_hi = 0, m_lo = 0, prev_hi = 0, prev_lo = 0;
    logic [5:0]  legal_fn [20] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                   6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                   6'h10, 6'h12, 6'h18, 6'h19};

    alu_exec_unit_if #(.WIDTH(32)) io ();

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_shl(input logic [31:0] v, input int s);
        logic [63:0] t;
        t = {32'd0, v} * (64'd1 << s);
        return t[31:0];
    endfunction

    function automatic logic [31:0] m_srl(input logic [31:0] v, input int s);
        return v / (32'd1 << s);
    endfunction

    function automatic logic [31:0] m_sra(input logic [31:0] v, input int s);
        longint sv, d, q;
        sv = longint'($signed(v));
        d  = longint'(1) << s;
        if (sv >= 0) q = sv / d;
        else         q = -((-sv + d - 1) / d);
        return q[31:0];
    endfunction

    // Reference model: expected response for one issued op; updates the architectural HI/LO on multiplies.
    task automatic model(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b, input bit old_hilo,
                         output exp_t e, output bit is_mul);
        longint      sa, sb_, ps;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        is_mul = 0;
        e.ill = 0;
        r = 0;
        if (op == 2'b00)      r = a + b;
        else if (op == 2'b01) r = a - b;
        else begin
            case (fn)
                6'h20, 6'h21: r = a + b;
                6'h22, 6'h23: r = a - b;
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h26: r = a ^ b;
                6'h27: r = ~(a | b);
                6'h2a: r = (sa < sb_) ? 32'd1 : 32'd0;
                6'h2b: r = (a < b) ? 32'd1 : 32'd0;
                6'h00: r = m_shl(b, int'(sh));
                6'h02: r = m_srl(b, int'(sh));
                6'h03: r = m_sra(b, int'(sh));
                6'h04: r = m_shl(b, int'(a % 32));
                6'h06: r = m_srl(b, int'(a % 32));
                6'h07: r = m_sra(b, int'(a % 32));
                6'h10: r = old_hilo ? prev_hi : m_hi;
                6'h12: r = old_hilo ? prev_lo : m_lo;
                6'h18, 6'h19: begin
                    if (fn == 6'h18) begin
                        ps = sa * sb_;
                        p  = ps;
                    end else begin
                        p = {32'd0, a} * {32'd0, b};
                    end
                    is_mul  = 1;
                    prev_hi = m_hi;
                    prev_lo = m_lo;
                    m_hi    = p[63:32];
                    m_lo    = p[31:0];
                    r       = p[31:0];
                end
                default: begin
                    e.ill = 1;
                    r = 0;
                end
            endcase
        end
        e.result = r;
        e.zero   = (r == 0);
        e.hi     = m_hi;
        e.lo     = m_lo;
    endtask

    // Issue one op at a negedge, wait (bounded) for done, and check latency and busy length.
    task automatic run_op(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                          input logic [31:0] a, input logic [31:0] b,
                          input int stray_at, input bit gap, input bit old_hilo);
        exp_t e;
        bit   is_mul;
        int   cyc, busy_cnt;
        model(op, fn, sh, a, b, old_hilo, e, is_mul);
        sb.push_back(e);
        io.alu_op = op; io.fn_field = fn; io.shamt = sh; io.a = a; io.b = b; io.start = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
        cyc = 1;
        busy_cnt = 0;
        while (!io.done && cyc < 100) begin
            busy_cnt += int'(io.busy);
            if (cyc == stray_at) begin
                io.a = 32'd7; io.b = 32'd7; io.fn_field = 6'h19; io.start = 1'b1;
            end else begin
                io.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        io.start = 1'b0;
        check("latency", 64'(cyc), is_mul ? 64'd33 : 64'd1);
        check("busy_cycles", 64'(busy_cnt), is_mul ? 64'd32 : 64'd0);
        if (gap) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (io.done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 with no pending op at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result",  64'(io.result),  64'(e.result));
                check("zero",    64'(io.zero),    64'(e.zero));
                check("illegal", 64'(io.illegal), 64'(e.ill));
                check("hi",      64'(io.hi),      64'(e.hi));
                check("lo",      64'(io.lo),      64'(e.lo));
            end
        end
    end

    initial begin
        io.start = 1'b1;
        io.alu_op = 2'($urandom); io.fn_field = 6'($urandom); io.shamt = 5'($urandom);
        io.a = $urandom; io.b = $urandom;
        repeat (2) @(negedge clk);
        check("rst_result",  64'(io.result),  64'd0);
        check("rst_zero",    64'(io.zero),    64'd1);
        check("rst_hi",      64'(io.hi),      64'd0);
        check("rst_lo",      64'(io.lo),      64'd0);
        check("rst_busy",    64'(io.busy),    64'd0);
        check("rst_done",    64'(io.done),    64'd0);
        check("rst_illegal", 64'(io.illegal), 64'd0);
        io.start = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        run_op(2'b00, 6'h00, 5'd0, 32'd5, 32'hFFFFFFFB, 0, 1, 0);
        run_op(2'b01, 6'h00, 5'd0, 32'd3, 32'd5, 0, 1, 0);
        run_op(2'b10, 6'h2a, 5'd0, 32'hFFFFFFFF, 32'd1, 0, 1, 0);
        run_op(2'b10, 6'h2b, 5'd0, 32'hFFFFFFFF, 32'd1, 0, 1, 0);
        run_op(2'b10, 6'h03, 5'd4, 32'd0, 32'h80000000, 0, 1, 0);
        run_op(2'b10, 6'h18, 5'd0, -32'sd3, 32'd7, 0, 1, 0);
        run_op(2'b10, 6'h12, 5'd0, 32'd0, 32'd0, 0, 1, 0);
        run_op(2'b10, 6'h19, 5'd0, 32'hFFFFFFFF, 32'd2, 0, 1, 0);

        // Multiply, then mfhi issued in the very cycle done is shown.
        run_op(2'b10, 6'h18, 5'd0, 32'h12345678, -32'sd99, 0, 0, 0);
        run_op(2'b10, 6'h10, 5'd0, 32'd0, 32'd0, 0, 1, 1);

        // Second start during the multiply must be ignored.
        run_op(2'b10, 6'h18, 5'd0, 32'd100, -32'sd9, 4, 1, 0);

        // Reset part-way through a multiply.
        io.alu_op = 2'b10; io.fn_field = 6'h19; io.a = 32'hDEADBEEF; io.b = 32'h1234; io.start = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        m_hi = 0; m_lo = 0; prev_hi = 0; prev_lo = 0;
        check("abort_busy", 64'(io.busy), 64'd0);
        check("abort_done", 64'(io.done), 64'd0);
        check("abort_hi",   64'(io.hi),   64'd0);
        check("abort_lo",   64'(io.lo),   64'd0);
        repeat (40) @(negedge clk);
        run_op(2'b10, 6'h3f, 5'd0, $urandom, $urandom, 0, 1, 0);

        for (int i = 0; i < 80; i++) begin
            logic [1:0] op;
            logic [5:0] fn;
            op = 2'($urandom_range(0, 3));
            fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 19)];
            run_op(op, fn, 5'($urandom), $urandom, $urandom, 0, 1, 0);
        end

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised successor of the ALU-control decoder: decode and execute in one registered unit.
- Decodes ALU op plus R-type function field, executes the operation, and registers result and zero flag.
- Adds shifts, unsigned ops, an iterative multiplier with HI/LO registers and a start/busy/done handshake.
- Sits in the multicycle datapath between the register A/B latches and ALUOut; the main control FSM waits on done.

Parameters:
- WIDTH, 32, datapath width in bits (>=8, power of 2).
- SH_W, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- alu_op  input  2  00 add (lw/sw), 01 sub (beq), 1x decode fn_field
- fn_field  input  6  instruction funct bits
- shamt  input  SH_W  immediate shift amount
- start  input  1  launch operation; sampled only when busy=0
- a  input  WIDTH  operand A (rs)
- b  input  WIDTH  operand B (rt/imm)
- result  output  WIDTH  registered result
- zero  output  1  registered (result==0)
- busy  output  1  multi-cycle operation in progress
- done  output  1  one-cycle pulse: result/HI/LO valid
- illegal  output  1  one-cycle pulse with done: unknown funct
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (synchronous, active-high): result=0, zero=1, busy=0, done=0, illegal=0, hi=0, lo=0, FSM=IDLE. Reset mid-multiply aborts it; HI/LO are not updated.
- Decode is exact; no don't-care funct matching. Funct codes for alu_op=1x:
  - 100000/100001 add; 100010/100011 sub; 100100 and; 100101 or; 100110 xor; 100111 nor.
  - 101010 slt (signed); 101011 sltu.
  - 000000 sll, 000010 srl, 000011 sra by shamt.
  - 000100 sllv, 000110 srlv, 000111 srav by a[SH_W-1:0]; shifted operand is b.
  - 010000 mfhi; 010010 mflo; 011000 mult; 011001 multu.
- Arithmetic wraps modulo 2^WIDTH; no overflow trap. slt/sltu result is 0 or 1, zero-extended.
- FSM states IDLE, MUL, FIX:
  - IDLE + start + single-cycle op: at the next edge result, zero and done=1 (1-cycle latency); stays IDLE.
  - IDLE + start + mult/multu: latch operands into |a| and |b| for mult (raw for multu), record product sign, clear the 2*WIDTH accumulator and set counter=WIDTH-1. Go to MUL; busy=1 from the next cycle.
  - MUL: one shift-add iteration per cycle. When counter reaches 0, go to FIX.
  - FIX: negate the product if the recorded sign is negative. Write {hi,lo}, set result=lo, update zero, pulse done, go to IDLE, busy=0.
  - Total multiply latency: start at cycle T gives done at T+WIDTH+1.
- start while busy=1 is ignored: no queueing, operands not resampled.
- mfhi/mflo issued in the same cycle that done is pulsed for a multiply return the old HI/LO. That cycle has busy=0 and start is accepted.
- Illegal funct: result=0, zero=1, done=1 and illegal=1 at the next edge; HI/LO unchanged.
- done and illegal are high for exactly one cycle. Outputs hold their values between operations.
- Operand and alu_op changes without start have no effect.

Decomposition:
- Shared package alu_pkg:
  - Localparam constants for alu_op codes and every funct code above.
  - Enum typedef for the FSM state.
  - Internal op enum produced by decode (OP_ADD … OP_MULTU, OP_ILL).
- One natural sub-module: alu_mul_iter. It holds the shift-add datapath and counter, with inputs start/signed/a/b and outputs busy/done/product. alu_exec_unit keeps decode, the single-cycle ALU, the result/zero registers and HI/LO.

Test Plan:
- Reset: assert reset with all inputs random for 2 cycles -> result=0, zero=1, hi=lo=0, busy=done=0.
- alu_op=00, a=5, b=0xFFFFFFFB, start -> next cycle result=0, zero=1, done=1. Then alu_op=01, a=3, b=5 -> result=0xFFFFFFFE, zero=0.
- alu_op=10:
  - funct 101010, a=0xFFFFFFFF, b=1 -> result=1.
  - funct 101011, same operands -> result=0.
  - funct 000011, b=0x80000000, shamt=4 -> result=0xF8000000.
- mult, a=-3, b=7, start at T -> busy T+1..T+32, done at T+33, hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then mflo -> 0xFFFFFFEB; multu with a=0xFFFFFFFF, b=2 -> hi=1, lo=0xFFFFFFFE.
- Second start pulsed at T+5 during mult with different operands -> ignored; final hi/lo match the first operands.
- Reset at T+10 during mult -> busy=0 next cycle, no done pulse, hi/lo=0. Then funct 111111 with start -> illegal=1, done=1, result=0.
